// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the memory / writeback stage.
package mem_wb_stage_pkg;

   // Stage sequencing: idle/accepting, waiting on data memory, one-cycle retire.
   typedef enum logic [1:0] {
      MWB_IDLE = 2'd0,
      MWB_REQ  = 2'd1,
      MWB_WB   = 2'd2
   } mwb_state_e;

   // Writeback data select, consumed by the register-file write mux in decode.
   localparam logic [1:0] WD_FROMALU = 2'd0;
   localparam logic [1:0] WD_FROMMEM = 2'd1;
   localparam logic [1:0] WD_FROMPC  = 2'd2;

   // Destination register select.
   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   // Instruction parked while its memory access is outstanding.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_add4;
      logic [31:0] aluout;
      logic        regwr;
      logic [1:0]  wdsel;
      logic [1:0]  rdsel;
      logic        is_load;
   } mwb_op_t;

   // Word accesses only: any set low address bit is an alignment fault.
   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/mem_wb_stage_timeout.sv
// Saturating wait counter for a data-memory request; flags the last allowed cycle.
module dm_timeout_cnt #(
   parameter int unsigned LIMIT = 255,
   parameter int unsigned CNT_W = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expire
);

   localparam logic [CNT_W-1:0] TOP  = CNT_W'(LIMIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt;

   // expire fires on the cycle whose increment would reach LIMIT, so the
   // request is visible for exactly LIMIT cycles before it is abandoned.
   assign expire = inc && (cnt == LAST);

   // Count un-acked request cycles; clear on reset or on entry to a new request.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous here, so it lives inside the clocked branch
      // and never appears in the sensitivity list.
      if (!rst || clr) begin
         cnt <= '0;
      end else if (inc && cnt != TOP) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory access and writeback staging between execute and the register file.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned DM_TIMEOUT = 255,
   parameter int unsigned CNT_W      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_instr,
   input  logic [31:0] ex_pc_add4,
   input  logic [31:0] ex_aluout,
   input  logic [31:0] ex_stdata,
   input  logic        ex_memrd,
   input  logic        ex_memwr,
   input  logic        ex_regwr,
   input  logic [1:0]  ex_wdsel,
   input  logic [1:0]  ex_rdsel,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic [31:0] wb_instr,
   output logic [31:0] wb_pc_add4,
   output logic [31:0] wb_aluout,
   output logic [31:0] wb_memout,
   output logic        wb_regwr,
   output logic [1:0]  wb_wdsel,
   output logic [1:0]  wb_rdsel,
   output logic        err,
   input  logic        err_clr
);

   mwb_state_e state;
   mwb_op_t    op;

   logic is_mem;
   logic bad_addr;
   logic start_req;
   logic wait_cyc;
   logic timeout;
   logic err_set;

   assign ex_ready  = (state == MWB_IDLE) && rst;
   assign is_mem    = ex_memrd || ex_memwr;
   assign bad_addr  = misaligned(ex_aluout);
   assign start_req = ex_ready && ex_valid && is_mem && !bad_addr;
   assign wait_cyc  = (state == MWB_REQ) && !dm_ack;
   assign err_set   = (ex_ready && ex_valid && is_mem && bad_addr) || timeout;

   dm_timeout_cnt #(
      .LIMIT (DM_TIMEOUT),
      .CNT_W (CNT_W)
   ) u_tmo (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_req),
      .inc    (wait_cyc),
      .expire (timeout)
   );

   // Stage FSM with registered memory-port and writeback outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= MWB_IDLE;
         op         <= '0;
         dm_req     <= 1'b0;
         dm_we      <= 1'b0;
         dm_addr    <= '0;
         dm_wdata   <= '0;
         wb_instr   <= '0;
         wb_pc_add4 <= '0;
         wb_aluout  <= '0;
         wb_memout  <= '0;
         wb_regwr   <= 1'b0;
         wb_wdsel   <= '0;
         wb_rdsel   <= '0;
         err        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch reads the
         // pre-edge value of state and op regardless of statement order.
         wb_regwr <= 1'b0;
         case (state)
            MWB_IDLE: begin
               if (ex_valid) begin
                  if (start_req) begin
                     state    <= MWB_REQ;
                     op       <= '{instr: ex_instr, pc_add4: ex_pc_add4,
                                   aluout: ex_aluout, regwr: ex_regwr,
                                   wdsel: ex_wdsel, rdsel: ex_rdsel,
                                   is_load: ex_memrd};
                     dm_req   <= 1'b1;
                     dm_we    <= ex_memwr && !ex_memrd;
                     dm_addr  <= ex_aluout;
                     dm_wdata <= ex_stdata;
                  end else begin
                     // ALU op, or a memory op rejected for alignment: retire now.
                     wb_instr   <= ex_instr;
                     wb_pc_add4 <= ex_pc_add4;
                     wb_aluout  <= ex_aluout;
                     wb_wdsel   <= ex_wdsel;
                     wb_rdsel   <= ex_rdsel;
                     wb_regwr   <= ex_regwr && !is_mem;
                  end
               end
            end
            MWB_REQ: begin
               if (dm_ack || timeout) begin
                  state      <= MWB_WB;
                  dm_req     <= 1'b0;
                  wb_instr   <= op.instr;
                  wb_pc_add4 <= op.pc_add4;
                  wb_aluout  <= op.aluout;
                  wb_wdsel   <= op.wdsel;
                  wb_rdsel   <= op.rdsel;
                  // An ack wins over a same-cycle timeout.
                  if (dm_ack) begin
                     wb_memout <= dm_rdata;
                     wb_regwr  <= op.regwr && op.is_load;
                  end
               end
            end
            MWB_WB:  state <= MWB_IDLE;
            default: state <= MWB_IDLE;
         endcase
         // A new fault takes priority over a clear in the same cycle.
         err <= err_set || (err && !err_clr);
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a transaction-level reference model.
module tb_mem_wb_stage;
   import mem_wb_stage_pkg::*;

   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_instr, ex_pc_add4, ex_aluout, ex_stdata;
   logic        ex_memrd, ex_memwr, ex_regwr;
   logic [1:0]  ex_wdsel, ex_rdsel;
   logic        dm_req, dm_we, dm_ack;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [31:0] wb_instr, wb_pc_add4, wb_aluout, wb_memout;
   logic        wb_regwr;
   logic [1:0]  wb_wdsel, wb_rdsel;
   logic        err, err_clr;

   int n_checks = 0;
   int n_fail   = 0;

   mem_wb_stage #(.DM_TIMEOUT(TMO), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_instr(ex_instr), .ex_pc_add4(ex_pc_add4),
      .ex_aluout(ex_aluout), .ex_stdata(ex_stdata),
      .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .ex_regwr(ex_regwr),
      .ex_wdsel(ex_wdsel), .ex_rdsel(ex_rdsel),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .wb_instr(wb_instr), .wb_pc_add4(wb_pc_add4),
      .wb_aluout(wb_aluout), .wb_memout(wb_memout),
      .wb_regwr(wb_regwr), .wb_wdsel(wb_wdsel), .wb_rdsel(wb_rdsel),
      .err(err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   typedef struct {
      logic [31:0] instr, pc, alu;
      bit          regwr;
      logic [1:0]  wd, rd;
      bit          load;
   } txn_t;

   txn_t        pend;
   bit          m_open = 0;     // a memory access is outstanding
   bit          m_wb   = 0;     // the retire cycle that follows a memory access
   int          m_age  = 0;     // un-acked cycles the access has waited
   logic [31:0] e_instr = 0, e_pc = 0, e_alu = 0, e_mem = 0;
   logic [1:0]  e_wd = 0, e_rd = 0;
   bit          e_regwr = 0, e_err = 0, e_we = 0;
   logic [31:0] e_addr = 0, e_wdata = 0;

   task automatic retire(input logic [31:0] i, p, a, input logic [1:0] wd, rd, input bit rw);
      e_instr = i; e_pc = p; e_alu = a; e_wd = wd; e_rd = rd; e_regwr = rw;
   endtask

   always @(posedge clk) begin : model
      bit set_err;
      if (!rst) begin
         m_open = 0; m_wb = 0; m_age = 0;
         e_instr = 0; e_pc = 0; e_alu = 0; e_mem = 0; e_wd = 0; e_rd = 0;
         e_regwr = 0; e_err = 0; e_we = 0; e_addr = 0; e_wdata = 0;
      end else begin
         set_err = 0;
         e_regwr = 0;
         if (m_wb) begin
            m_wb = 0;
         end else if (m_open) begin
            if (dm_ack) begin
               e_mem = dm_rdata;
               retire(pend.instr, pend.pc, pend.alu, pend.wd, pend.rd, pend.regwr && pend.load);
               m_open = 0; m_wb = 1;
            end else begin
               m_age++;
               if (m_age >= TMO) begin
                  set_err = 1;
                  retire(pend.instr, pend.pc, pend.alu, pend.wd, pend.rd, 0);
                  m_open = 0; m_wb = 1;
               end
            end
         end else if (ex_valid) begin
            if (!(ex_memrd || ex_memwr)) begin
               retire(ex_instr, ex_pc_add4, ex_aluout, ex_wdsel, ex_rdsel, ex_regwr);
            end else if (ex_aluout % 4 != 0) begin
               set_err = 1;
               retire(ex_instr, ex_pc_add4, ex_aluout, ex_wdsel, ex_rdsel, 0);
            end else begin
               pend = '{instr: ex_instr, pc: ex_pc_add4, alu: ex_aluout, regwr: ex_regwr,
                        wd: ex_wdsel, rd: ex_rdsel, load: ex_memrd};
               m_open = 1; m_age = 0;
               e_we = ex_memwr && !ex_memrd;
               e_addr = ex_aluout; e_wdata = ex_stdata;
            end
         end
         if (set_err) e_err = 1;
         else if (err_clr) e_err = 0;
      end
   end

   // Mid-cycle comparison of every output against the model.
   always @(negedge clk) begin
      check("ex_ready", ex_ready, rst && !m_open && !m_wb);
      check("dm_req", dm_req, m_open);
      check("wb_regwr", wb_regwr, e_regwr);
      check("err", err, e_err);
      check("wb_instr", wb_instr, e_instr);
      check("wb_pc_add4", wb_pc_add4, e_pc);
      check("wb_aluout", wb_aluout, e_alu);
      check("wb_memout", wb_memout, e_mem);
      check("wb_wdsel", wb_wdsel, e_wd);
      check("wb_rdsel", wb_rdsel, e_rd);
      if (m_open) begin
         check("dm_we", dm_we, e_we);
         check("dm_addr", dm_addr, e_addr);
         check("dm_wdata", dm_wdata, e_wdata);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] alu, std, input bit rd, wr, rw, input logic [1:0] wd);
      ex_valid = 1; ex_aluout = alu; ex_stdata = std;
      ex_memrd = rd; ex_memwr = wr; ex_regwr = rw;
      ex_wdsel = wd; ex_rdsel = RD_RD;
      ex_instr = 32'hA500_0000 | alu; ex_pc_add4 = 32'h0040_0000 + alu;
   endtask

   task automatic idle_in();
      ex_valid = 0; ex_memrd = 0; ex_memwr = 0; ex_regwr = 0;
   endtask

   initial begin
      rst = 0; err_clr = 0; dm_ack = 0; dm_rdata = 0;
      ex_valid = 0; ex_instr = 0; ex_pc_add4 = 0; ex_aluout = 0; ex_stdata = 0;
      ex_memrd = 0; ex_memwr = 0; ex_regwr = 0; ex_wdsel = 0; ex_rdsel = 0;

      // Reset state
      step(); step();
      check("rst_ready", ex_ready, 0);
      check("rst_dm_req", dm_req, 0);
      check("rst_wb_aluout", wb_aluout, 0);
      check("rst_err", err, 0);
      rst = 1; #1;
      check("ready_after_rst", ex_ready, 1);

      // ALU ops back to back
      drive(32'h11, 0, 0, 0, 1, WD_FROMALU); step();
      check("alu0_out", wb_aluout, 32'h11); check("alu0_rw", wb_regwr, 1); check("alu0_rdy", ex_ready, 1);
      drive(32'h22, 0, 0, 0, 1, WD_FROMALU); step();
      check("alu1_out", wb_aluout, 32'h22); check("alu1_rw", wb_regwr, 1);
      drive(32'h33, 0, 0, 0, 1, WD_FROMALU); step();
      check("alu2_out", wb_aluout, 32'h33); check("alu2_rw", wb_regwr, 1);
      idle_in(); step();
      check("alu_hold", wb_aluout, 32'h33); check("alu_pulse_end", wb_regwr, 0);

      // Load, ack on third request cycle
      drive(32'h1000, 0, 1, 0, 1, WD_FROMMEM); step();
      check("ld_req", dm_req, 1); check("ld_addr", dm_addr, 32'h1000);
      check("ld_we", dm_we, 0); check("ld_rdy", ex_ready, 0);
      idle_in(); step(); step();
      dm_ack = 1; dm_rdata = 32'hDEADBEEF; step();
      dm_ack = 0;
      check("ld_memout", wb_memout, 32'hDEADBEEF); check("ld_rw", wb_regwr, 1);
      check("ld_wb_req", dm_req, 0); check("ld_wb_rdy", ex_ready, 0);
      step();
      check("ld_back_rdy", ex_ready, 1);

      // Store with immediate ack; regwr requested but must never pulse
      drive(32'h2004, 32'hCAFEF00D, 0, 1, 1, WD_FROMALU); step();
      check("st_we", dm_we, 1); check("st_wdata", dm_wdata, 32'hCAFEF00D);
      idle_in(); dm_ack = 1; dm_rdata = 32'h5707E000; step();
      dm_ack = 0;
      check("st_rw", wb_regwr, 0);
      step();

      // Stray ack while idle is ignored
      dm_ack = 1; dm_rdata = 32'hFFFFFFFF; step();
      dm_ack = 0;
      check("stray_memout", wb_memout, 32'h5707E000); check("stray_req", dm_req, 0);

      // Both memrd and memwr: behaves as a load
      drive(32'h3000, 32'h1, 1, 1, 1, WD_FROMMEM); step();
      check("rdwr_we", dm_we, 0);
      idle_in(); dm_ack = 1; dm_rdata = 32'h12345678; step();
      dm_ack = 0;
      check("rdwr_rw", wb_regwr, 1);
      step();

      // Misaligned load
      drive(32'h1002, 0, 1, 0, 1, WD_FROMMEM); step();
      check("mis_req", dm_req, 0); check("mis_err", err, 1);
      check("mis_rw", wb_regwr, 0); check("mis_alu", wb_aluout, 32'h1002);
      idle_in(); err_clr = 1; step();
      err_clr = 0;
      check("mis_clr", err, 0);

      // Set wins over clear
      drive(32'h1003, 0, 1, 0, 1, WD_FROMMEM); err_clr = 1; step();
      check("set_wins", err, 1);
      idle_in(); step();
      err_clr = 0;
      check("clr_again", err, 0);

      // Timeout after exactly TMO request cycles
      drive(32'h4000, 0, 1, 0, 1, WD_FROMMEM); step();
      idle_in(); step(); step(); step();
      check("tmo_req4", dm_req, 1);
      step();
      check("tmo_req", dm_req, 0); check("tmo_err", err, 1);
      check("tmo_rw", wb_regwr, 0); check("tmo_rdy_wb", ex_ready, 0);
      step();
      check("tmo_rdy", ex_ready, 1);
      err_clr = 1; step(); err_clr = 0;

      // Ack on the last allowed cycle beats the timeout
      drive(32'h4100, 0, 1, 0, 1, WD_FROMMEM); step();
      idle_in(); step(); step(); step();
      dm_ack = 1; dm_rdata = 32'h0BADF00D; step();
      dm_ack = 0;
      check("edge_rw", wb_regwr, 1); check("edge_err", err, 0);
      check("edge_mem", wb_memout, 32'h0BADF00D);
      step();

      // Reset on second request cycle
      drive(32'h5000, 0, 1, 0, 1, WD_FROMMEM); step();
      idle_in(); step();
      rst = 0; step();
      check("rr_req", dm_req, 0); check("rr_alu", wb_aluout, 0);
      check("rr_mem", wb_memout, 0); check("rr_instr", wb_instr, 0);
      rst = 1; step();
      drive(32'h6000, 0, 1, 0, 1, WD_FROMMEM); step();
      idle_in(); dm_ack = 1; dm_rdata = 32'h600D600D; step();
      dm_ack = 0;
      check("rr_ld_mem", wb_memout, 32'h600D600D); check("rr_ld_rw", wb_regwr, 1);
      step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Sits between execute and the ID/regfile writeback port.
- Accepts one executed instruction per handshake, performs the data-memory access for loads and stores, and drives the writeback bundle (RegWr, WDSel, RDSel, ALU result, memory result, pc+4, instr) consumed by the register-file write mux in decode.
- Non-memory ops retire in 1 cycle. Memory ops block upstream until the memory acks or times out.

Parameters:
- DM_TIMEOUT, 255, max cycles dm_req stays high without dm_ack before the access is abandoned (1..65535).
- CNT_W, 16, width of the timeout counter; must hold DM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage can accept this cycle
- ex_instr  in  32  instruction word
- ex_pc_add4  in  32  pc+4 of the instruction
- ex_aluout  in  32  ALU result / memory address
- ex_stdata  in  32  store data (rt value)
- ex_memrd  in  1  instruction is a load
- ex_memwr  in  1  instruction is a store
- ex_regwr  in  1  instruction writes the register file
- ex_wdsel  in  2  WD_* select
- ex_rdsel  in  2  RD_* select
- dm_req  out  1  memory request, held until ack or timeout
- dm_we  out  1  request is a write
- dm_addr  out  32  word address (ex_aluout, low 2 bits zero)
- dm_wdata  out  32  store data
- dm_ack  in  1  memory completes the request this cycle
- dm_rdata  in  32  load data, valid with dm_ack
- wb_instr  out  32  to decode instr
- wb_pc_add4  out  32  to decode pc_add4
- wb_aluout  out  32  to decode ALUout
- wb_memout  out  32  to decode MEMout
- wb_regwr  out  1  to decode RegWr, one-cycle pulse per retired writing instruction
- wb_wdsel  out  2  to decode WDSel
- wb_rdsel  out  2  to decode RDSel
- err  out  1  sticky: misaligned access or memory timeout
- err_clr  in  1  clears err

Behaviour:
- Reset (rst=0 at edge): state IDLE. All outputs 0, except ex_ready=1 once rst=1.
- Reset mid-REQ drops dm_req at that edge; no writeback occurs and the counter clears.
- States: IDLE, REQ, WB.
  - ex_ready = (state==IDLE) && rst.
- IDLE, accept (ex_valid && ex_ready), non-memory op:
  - Next cycle the wb_* bundle holds the captured values and wb_regwr = ex_regwr for exactly 1 cycle.
  - Stay in IDLE; back-to-back accepts sustain 1 op/cycle.
- IDLE, accept, memory op:
  - If ex_aluout[1:0] != 0: no request. err set; retire next cycle with wb_regwr=0.
  - Otherwise go to REQ. dm_req=1, dm_we=ex_memwr, dm_addr and dm_wdata registered. wb_regwr=0 during REQ.
- REQ: counter increments each cycle dm_ack=0.
  - dm_ack=1: capture dm_rdata into wb_memout, drop dm_req, go to WB. dm_ack wins over a same-cycle timeout.
  - Counter reaches DM_TIMEOUT with no ack: drop dm_req, set err, go to WB with wb_regwr forced 0.
- WB: 1 cycle. wb_regwr = ex_regwr && load && no error. Stores always have wb_regwr=0. Then go to IDLE.
- wb_* data outputs hold their last values between retirements. Only wb_regwr pulses.
- dm_ack outside REQ is ignored.
- Both ex_memrd and ex_memwr set: treated as a load.
- err_clr and a new error in the same cycle: err=1 (set wins).
- Counter and arithmetic are unsigned and do not wrap; the counter clears on entry to REQ.

Decomposition:
- WD_* and RD_* encodings and the SEG_* field macros stay in defs.vh.
- Add MWB_IDLE/MWB_REQ/MWB_WB state codes to defs.vh.
- One natural sub-module: dm_timeout_cnt (load/clear, increment, terminal-count flag at DM_TIMEOUT).

Test Plan:
- ALU ops back-to-back: ex_valid=1 for 3 cycles with aluout 0x11, 0x22, 0x33, regwr=1, wdsel=WD_fromALU -> wb_aluout 0x11, 0x22, 0x33 on the next 3 cycles, wb_regwr=1 each, ex_ready stays 1.
- Load: aluout=0x1000, memrd=1, dm_ack after 3 cycles with rdata 0xDEADBEEF -> dm_req high 3 cycles, dm_addr=0x1000, dm_we=0; WB cycle has wb_memout=0xDEADBEEF, wb_regwr=1; ex_ready low for 4 cycles.
- Store: aluout=0x2004, stdata=0xCAFEF00D, memwr=1, immediate ack -> dm_we=1, dm_wdata=0xCAFEF00D, wb_regwr never asserted.
- Misaligned load: aluout=0x1002 -> dm_req stays 0, err=1, wb_regwr=0; err_clr clears err.
- Timeout with DM_TIMEOUT=4, no ack -> dm_req high exactly 4 cycles, err=1, wb_regwr=0, ex_ready returns 1 after WB.
- Reset during REQ: rst=0 on cycle 2 of a load -> dm_req=0 and all wb_* = 0 after the edge; a later load completes normally.
